// File: rtl/ds_adc_seq.sv
// Delta-sigma ADC sequencer: modulator cke divider, settle-sample discard,
// 2^N block averaging and valid/ready result hand-off.
module ds_adc_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic [7:0]       settle_cnt,
  input  logic [2:0]       avg_log2,
  output logic             cke,
  input  logic             adc_valid,
  input  logic [WIDTH-1:0] adc_data,
  output logic [WIDTH-1:0] res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned ACC_W = WIDTH + 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_ACQ
  } state_t;

  state_t                   state_q, state_d;
  logic [DIV_W-1:0]         div_q, div_d;
  logic [7:0]               settle_q, settle_d;
  logic [2:0]               avg_q, avg_d;
  logic [DIV_W-1:0]         dcnt_q, dcnt_d;
  logic [7:0]               scnt_q, scnt_d;
  logic [7:0]               acnt_q, acnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     cke_q, cke_d;
  logic [WIDTH-1:0]         res_data_q, res_data_d;
  logic                     res_valid_q, res_valid_d;
  logic                     overrun_q, overrun_d;

  logic                     start_ok;
  logic                     emit;
  logic                     handshake;
  logic [DIV_W-1:0]         div_eff;
  logic [7:0]               avg_last;
  logic signed [ACC_W-1:0]  acc_sum;
  logic [WIDTH-1:0]         res_new;

  assign start_ok  = (state_q == S_IDLE) && start && !stop;
  assign handshake = res_valid_q && res_ready;
  assign div_eff   = (div_ratio < DIV_W'(2)) ? DIV_W'(2) : div_ratio;
  assign avg_last  = (8'd1 << avg_q) - 8'd1;
  assign acc_sum   = acc_q + {{7{adc_data[WIDTH-1]}}, adc_data};
  // Arithmetic shift floors toward -inf; the quotient of a 2^N-sample sum always fits WIDTH.
  assign res_new   = WIDTH'(acc_sum >>> avg_q);

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    settle_d    = settle_q;
    avg_d       = avg_q;
    dcnt_d      = dcnt_q;
    scnt_d      = scnt_q;
    acnt_d      = acnt_q;
    acc_d       = acc_q;
    cke_d       = 1'b0;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    overrun_d   = overrun_q;
    emit        = 1'b0;

    if (state_q == S_IDLE) begin
      if (start_ok) begin
        div_d     = div_eff;
        settle_d  = settle_cnt;
        avg_d     = avg_log2;
        dcnt_d    = '0;
        scnt_d    = '0;
        acnt_d    = '0;
        acc_d     = '0;
        overrun_d = 1'b0;
        state_d   = (settle_cnt != 8'd0) ? S_SETTLE : S_ACQ;
      end
    end else if (stop) begin
      state_d = S_IDLE;
      dcnt_d  = '0;
      scnt_d  = '0;
      acnt_d  = '0;
      acc_d   = '0;
    end else begin
      if (dcnt_q == div_q - DIV_W'(1)) begin
        dcnt_d = '0;
        cke_d  = 1'b1;
      end else begin
        dcnt_d = dcnt_q + DIV_W'(1);
      end

      if (adc_valid) begin
        if (state_q == S_SETTLE) begin
          if (scnt_q == settle_q - 8'd1) begin
            scnt_d  = '0;
            state_d = S_ACQ;
          end else begin
            scnt_d = scnt_q + 8'd1;
          end
        end else if (acnt_q == avg_last) begin
          emit   = 1'b1;
          acc_d  = '0;
          acnt_d = '0;
        end else begin
          acc_d  = acc_sum;
          acnt_d = acnt_q + 8'd1;
        end
      end
    end

    // A result arriving on the handshake cycle replaces the one being consumed.
    if (emit && (!res_valid_q || handshake)) begin
      res_data_d  = res_new;
      res_valid_d = 1'b1;
    end else begin
      if (emit)      overrun_d   = 1'b1;
      if (handshake) res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      settle_q    <= '0;
      avg_q       <= '0;
      dcnt_q      <= '0;
      scnt_q      <= '0;
      acnt_q      <= '0;
      acc_q       <= '0;
      cke_q       <= 1'b0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      settle_q    <= settle_d;
      avg_q       <= avg_d;
      dcnt_q      <= dcnt_d;
      scnt_q      <= scnt_d;
      acnt_q      <= acnt_d;
      acc_q       <= acc_d;
      cke_q       <= cke_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign cke       = cke_q;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ds_adc_seq.sv
// Directed bench for ds_adc_seq: divider, settling, averaging, handshake/overrun, stop, reset.
module tb_ds_adc_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop;
  logic [7:0]  div_ratio;
  logic [7:0]  settle_cnt;
  logic [2:0]  avg_log2;
  logic        cke;
  logic        adc_valid;
  logic [15:0] adc_data;
  logic [15:0] res_data;
  logic        res_valid;
  logic        res_ready;
  logic        busy;
  logic        overrun;

  int unsigned total = 0;
  int unsigned bad   = 0;

  ds_adc_seq #(.WIDTH(16), .DIV_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .div_ratio  (div_ratio),
    .settle_cnt (settle_cnt),
    .avg_log2   (avg_log2),
    .cke        (cke),
    .adc_valid  (adc_valid),
    .adc_data   (adc_data),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop;
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic sample(input logic [15:0] d);
    adc_valid = 1'b1;
    adc_data  = d;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic test_reset;
    total++; if (cke !== 1'b0)        begin bad++; $display("FAIL rst_cke: got %b want 0", cke); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (res_valid !== 1'b0)  begin bad++; $display("FAIL rst_valid: got %b want 0", res_valid); end
    total++; if (overrun !== 1'b0)    begin bad++; $display("FAIL rst_ovr: got %b want 0", overrun); end
    total++; if (res_data !== 16'h0)  begin bad++; $display("FAIL rst_data: got %h want 0000", res_data); end
  endtask

  task automatic test_divider;
    div_ratio = 8'd4; settle_cnt = 8'd0; avg_log2 = 3'd0;
    pulse_start();
    div_ratio = 8'd2;  // must not take effect until the next start
    for (int k = 1; k <= 12; k++) begin
      tick();
      total++;
      if (cke !== ((k % 4) == 0)) begin
        bad++; $display("FAIL div4_cke k=%0d: got %b want %b", k, cke, (k % 4) == 0);
      end
    end
    pulse_stop();
    for (int k = 0; k < 6; k++) begin
      total++; if (cke !== 1'b0) begin bad++; $display("FAIL stop_cke k=%0d: got %b want 0", k, cke); end
      tick();
    end
    for (int r = 0; r < 2; r++) begin
      div_ratio = 8'(r);
      pulse_start();
      for (int k = 1; k <= 6; k++) begin
        tick();
        total++;
        if (cke !== ((k % 2) == 0)) begin
          bad++; $display("FAIL div%0d_cke k=%0d: got %b want %b", r, k, cke, (k % 2) == 0);
        end
      end
      pulse_stop();
    end
  endtask

  task automatic test_settle;
    logic [15:0] d [5];
    d = '{16'd100, 16'd200, 16'd300, 16'd400, 16'd500};
    div_ratio = 8'd4; settle_cnt = 8'd3; avg_log2 = 3'd0; res_ready = 1'b1;
    pulse_start();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL settle_busy: got %b want 1", busy); end
    for (int i = 0; i < 3; i++) begin
      sample(d[i]);
      total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL settle_discard i=%0d: got %b want 0", i, res_valid); end
      tick();
    end
    for (int i = 3; i < 5; i++) begin
      sample(d[i]);
      total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL settle_valid i=%0d: got %b want 1", i, res_valid); end
      total++; if (res_data !== d[i])  begin bad++; $display("FAIL settle_data i=%0d: got %0d want %0d", i, res_data, d[i]); end
      tick();
      total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL settle_consumed i=%0d: got %b want 0", i, res_valid); end
    end
    pulse_stop();
    res_ready = 1'b0;
  endtask

  task automatic test_average;
    logic [15:0] s [12];
    logic [15:0] exp_r [3];
    s = '{16'd1, 16'd2, 16'd3, 16'hFFF6,
          16'd1, 16'd1, 16'd1, 16'd2,
          16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    exp_r = '{16'hFFFF, 16'h0001, 16'h7FFF};
    settle_cnt = 8'd0; avg_log2 = 3'd2; res_ready = 1'b1;
    pulse_start();
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 3; i++) sample(s[b*4 + i]);
      total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL avg_early b=%0d: got %b want 0", b, res_valid); end
      sample(s[b*4 + 3]);
      total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL avg_valid b=%0d: got %b want 1", b, res_valid); end
      total++;
      if (res_data !== exp_r[b]) begin
        bad++; $display("FAIL avg_data b=%0d: got %0d want %0d", b, $signed(res_data), $signed(exp_r[b]));
      end
      tick();
    end
    pulse_stop();
    res_ready = 1'b0;
  endtask

  task automatic test_overrun;
    settle_cnt = 8'd0; avg_log2 = 3'd0; res_ready = 1'b0;
    pulse_start();
    sample(16'd11);
    total++; if (res_data !== 16'd11 || res_valid !== 1'b1) begin bad++; $display("FAIL ovr_first: got %0d/%b want 11/1", res_data, res_valid); end
    res_ready = 1'b1;
    sample(16'd22);
    res_ready = 1'b0;
    total++; if (res_data !== 16'd22 || res_valid !== 1'b1) begin bad++; $display("FAIL ovr_swap: got %0d/%b want 22/1", res_data, res_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_swap_flag: got %b want 0", overrun); end
    sample(16'd33);
    total++; if (res_data !== 16'd22 || res_valid !== 1'b1) begin bad++; $display("FAIL ovr_hold: got %0d/%b want 22/1", res_data, res_valid); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL ovr_consume: got %b want 0", res_valid); end
    pulse_stop();
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    pulse_start();
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    pulse_stop();
  endtask

  task automatic test_stop_restart;
    settle_cnt = 8'd0; avg_log2 = 3'd2; res_ready = 1'b0;
    pulse_start();
    sample(16'd5);
    sample(16'd5);
    pulse_stop();
    total++; if (busy !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("FAIL stop_mid: got busy=%b valid=%b want 0/0", busy, res_valid); end
    pulse_start();
    sample(16'd1); sample(16'd2); sample(16'd3); sample(16'hFFF6);
    total++; if (res_valid !== 1'b1 || res_data !== 16'hFFFF) begin bad++; $display("FAIL restart_data: got %0d/%b want -1/1", $signed(res_data), res_valid); end
    pulse_stop();
    total++; if (res_valid !== 1'b1 || res_data !== 16'hFFFF || busy !== 1'b0) begin bad++; $display("FAIL stop_keeps_result: got %0d/%b busy=%b want -1/1 busy=0", $signed(res_data), res_valid, busy); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++; if (busy !== 1'b0 || cke !== 1'b0) begin bad++; $display("FAIL start_stop k=%0d: got busy=%b cke=%b want 0/0", k, busy, cke); end
      tick();
    end
  endtask

  task automatic test_async_reset;
    div_ratio = 8'd4; settle_cnt = 8'd0; avg_log2 = 3'd0; res_ready = 1'b0;
    pulse_start();
    sample(16'd7);
    sample(16'd8);
    tick();
    tick();
    total++; if (cke !== 1'b1 || overrun !== 1'b1 || res_valid !== 1'b1) begin bad++; $display("FAIL prereset: got cke=%b ovr=%b valid=%b want 1/1/1", cke, overrun, res_valid); end
    #3 rst_n = 1'b0;
    #1;
    total++; if (cke !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL areset_ctl: got cke=%b busy=%b want 0/0", cke, busy); end
    total++; if (res_valid !== 1'b0 || overrun !== 1'b0 || res_data !== 16'h0) begin bad++; $display("FAIL areset_res: got valid=%b ovr=%b data=%h want 0/0/0000", res_valid, overrun, res_data); end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      total++; if (cke !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL post_reset k=%0d: got cke=%b busy=%b want 0/0", k, cke, busy); end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    div_ratio = 8'd4; settle_cnt = 8'd0; avg_log2 = 3'd0;
    adc_valid = 1'b0; adc_data = 16'h0; res_ready = 1'b0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_divider();
    test_settle();
    test_average();
    test_overrun();
    test_stop_restart();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
